// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions for the neuron-array generator and checker.
// One tap table keeps both ends of the link on the same polynomial.
package lfsr_checker_pkg;

    // Bit k-1 set means 1-indexed tap k feeds the XNOR; widths 3..32
    function automatic logic [31:0] lfsr_taps(input int n);
        logic [31:0] m;
        m = 32'h0;
        case (n)
            3:  m = 32'h0000_0006;
            4:  m = 32'h0000_000C;
            5:  m = 32'h0000_0014;
            6:  m = 32'h0000_0030;
            7:  m = 32'h0000_0060;
            8:  m = 32'h0000_00B8;
            9:  m = 32'h0000_0110;
            10: m = 32'h0000_0240;
            11: m = 32'h0000_0500;
            12: m = 32'h0000_0829;
            13: m = 32'h0000_100D;
            14: m = 32'h0000_2015;
            15: m = 32'h0000_6000;
            16: m = 32'h0000_D008;
            17: m = 32'h0001_2000;
            18: m = 32'h0002_0400;
            19: m = 32'h0004_0023;
            20: m = 32'h0009_0000;
            21: m = 32'h0014_0000;
            22: m = 32'h0030_0000;
            23: m = 32'h0042_0000;
            24: m = 32'h00E1_0000;
            25: m = 32'h0120_0000;
            26: m = 32'h0200_0023;
            27: m = 32'h0400_0013;
            28: m = 32'h0900_0000;
            29: m = 32'h1400_0000;
            30: m = 32'h2000_0029;
            31: m = 32'h4800_0000;
            32: m = 32'h8020_0003;
            default: m = 32'h0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_checker_next.sv
// Combinational next-word function of the XNOR Fibonacci LFSR.
// Shift left, feedback enters at bit 0.
module lfsr_next
    import lfsr_checker_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic [DSIZE-1:0] i_w,
    output logic [DSIZE-1:0] o_nxt
);

    localparam logic [31:0] TAPS = lfsr_taps(DSIZE);

    logic w_fb;

    assign w_fb  = ~^(i_w & TAPS[DSIZE-1:0]);
    assign o_nxt = {i_w[DSIZE-2:0], w_fb};

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising XNOR LFSR stream checker: seeds, locks, then
// flywheels its prediction and counts mismatches for BIST.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int DSIZE    = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             dat_vld_i,
    input  logic [DSIZE-1:0] dat_i,
    output logic             locked_o,
    output logic             err_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            r_state, w_state;
    logic              r_seeded, w_seeded;
    logic [DSIZE-1:0]  r_exp, w_exp;
    logic [RUN_W-1:0]  r_run, w_run;
    logic [MISS_W-1:0] r_miss, w_miss;
    logic              r_err, w_err;
    logic              r_ill, w_ill;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_inc;

    logic [DSIZE-1:0]  w_nxt_dat;
    logic [DSIZE-1:0]  w_nxt_exp;
    logic              w_ones;
    logic              w_match;
    logic [RUN_W-1:0]  w_run_inc;
    logic [MISS_W-1:0] w_miss_inc;

    lfsr_next #(.DSIZE(DSIZE)) u_nxt_dat (
        .i_w   (dat_i),
        .o_nxt (w_nxt_dat)
    );

    lfsr_next #(.DSIZE(DSIZE)) u_nxt_exp (
        .i_w   (r_exp),
        .o_nxt (w_nxt_exp)
    );

    assign w_ones     = &dat_i;
    assign w_match    = (dat_i == r_exp) && !w_ones;
    assign w_run_inc  = r_run + 1'b1;
    assign w_miss_inc = r_miss + 1'b1;

    always_comb begin
        w_state  = r_state;
        w_seeded = r_seeded;
        w_exp    = r_exp;
        w_run    = r_run;
        w_miss   = r_miss;
        w_err    = 1'b0;
        w_ill    = 1'b0;
        w_inc    = 1'b0;
        if (dat_vld_i) begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_ones) begin
                        w_ill    = 1'b1;
                        w_seeded = 1'b0;
                        w_run    = '0;
                    end else if (!r_seeded) begin
                        w_exp    = w_nxt_dat;
                        w_seeded = 1'b1;
                        w_run    = '0;
                    end else if (w_match) begin
                        w_exp = w_nxt_dat;
                        w_run = w_run_inc;
                        if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                            w_state = ST_LOCKED;
                            w_miss  = '0;
                        end
                    end else begin
                        w_exp = w_nxt_dat;
                        w_run = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: a bad word never disturbs the prediction
                    w_exp = w_nxt_exp;
                    w_ill = w_ones;
                    if (w_match) begin
                        w_miss = '0;
                    end else begin
                        w_err  = 1'b1;
                        w_inc  = 1'b1;
                        w_miss = w_miss_inc;
                        if (w_miss_inc == MISS_W'(LOSS_CNT)) begin
                            w_state  = ST_SEARCH;
                            w_seeded = 1'b0;
                            w_run    = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= ST_SEARCH;
            r_seeded <= 1'b0;
            r_exp    <= '0;
            r_run    <= '0;
            r_miss   <= '0;
            r_err    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_seeded <= w_seeded;
            r_exp    <= w_exp;
            r_run    <= w_run;
            r_miss   <= w_miss;
            r_err    <= w_err;
            r_ill    <= w_ill;
        end
    end

    // Clear wins over a same-cycle increment
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (w_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign locked_o  = (r_state == ST_LOCKED);
    assign err_o     = r_err;
    assign illegal_o = r_ill;
    assign err_cnt_o = r_cnt;

endmodule
